// File: rtl/element_addition_cut_vec_pkg.sv
// Shared types, mode constants and the saturating add used by every lane.
package element_addition_cut_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_t;

  localparam int CUT_MODE_CLIP = 0;
  localparam int CUT_MODE_SIGN = 1;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } sat_result_t;

  // Add two sign-extended operands and clamp to a signed range of 'width' bits.
  function automatic sat_result_t sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        width);
    sat_result_t        r;
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum     = a + b;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    r.value = sum;
    r.sat   = 1'b0;
    if (sum > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (sum < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/element_addition_cut_vec_if.sv
// Framed input stream and valid/ready result port of the bundler.
interface element_addition_cut_vec_if #(
  parameter int LANES       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_first;
  logic                        in_last;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [COUNT_WIDTH-1:0]      out_count;
  logic                        sat_flag;
  logic                        frame_err;

  modport master (
    output in_valid, in_first, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count, sat_flag, frame_err
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count, sat_flag, frame_err
  );
endinterface

// File: rtl/element_addition_cut_vec_lane.sv
// One lane: saturating accumulator plus the clip / sign cut of its next value.
module bipolar_sat_accum_lane
  import element_addition_cut_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int CUT        = 1,
  parameter int MODE       = CUT_MODE_CLIP,
  parameter int TIE_POS    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         accum,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic signed [DATA_WIDTH-1:0] cut_data,
  output logic                         sat
);

  localparam logic signed [63:0]           CUT_W = 64'(CUT);
  localparam logic signed [DATA_WIDTH-1:0] CUT_D = DATA_WIDTH'(CUT);
  localparam logic signed [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [63:0]          acc_wide;
  sat_result_t                 add_res;

  // Next accumulator value: reload on frame start, saturating add on other beats.
  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    add_res  = sat_add(64'(acc), 64'(data), ACC_WIDTH);
    acc_wide = 64'(acc);
    sat      = 1'b0;
    if (load) begin
      acc_wide = 64'(data);
    end else if (accum) begin
      acc_wide = add_res.value;
      sat      = add_res.sat;
    end
  end

  // Cut the post-beat value so the final beat is already included in the result.
  always_comb begin
    cut_data = acc_wide[DATA_WIDTH-1:0];
    if (MODE == CUT_MODE_SIGN) begin
      if (acc_wide > 64'sd0)      cut_data = ONE_D;
      else if (acc_wide < 64'sd0) cut_data = -ONE_D;
      else                        cut_data = (TIE_POS != 0) ? ONE_D : -ONE_D;
    end else begin
      if (acc_wide > CUT_W)       cut_data = CUT_D;
      else if (acc_wide < -CUT_W) cut_data = -CUT_D;
    end
  end

  // Accumulator register; a reset mid-frame drops the partial sum.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) acc <= '0;
    else       acc <= acc_wide[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/element_addition_cut_vec.sv
// Multi-lane saturating bundler: accumulates a framed stream, emits a cut chunk per frame.
module element_addition_cut_vec
  import element_addition_cut_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int CUT         = 1,
  parameter int MODE        = CUT_MODE_CLIP,
  parameter int TIE_POS     = 1,
  parameter int COUNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      reset,
  element_addition_cut_vec_if.slave bus
);

  state_t                      state;
  state_t                      state_next;
  logic                        accept;
  logic                        load;
  logic                        accum;
  logic [LANES-1:0]            lane_sat;
  logic [LANES*DATA_WIDTH-1:0] cut_bus;
  logic [LANES*DATA_WIDTH-1:0] out_data_r;
  logic [COUNT_WIDTH-1:0]      count;
  logic                        sat_flag_r;
  logic                        frame_err_r;

  assign bus.in_ready  = !reset && (state == S_IDLE || state == S_ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = out_data_r;
  assign bus.out_count = count;
  assign bus.sat_flag  = sat_flag_r;
  assign bus.frame_err = frame_err_r;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bipolar_sat_accum_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .CUT       (CUT),
      .MODE      (MODE),
      .TIE_POS   (TIE_POS)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .accum   (accum),
      .data    (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .cut_data(cut_bus[i*DATA_WIDTH +: DATA_WIDTH]),
      .sat     (lane_sat[i])
    );
  end

  // Next state and lane controls; a first beat inside an open frame restarts it.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    accum      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = bus.in_last ? S_OUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          load       = bus.in_first;
          accum      = !bus.in_first;
          state_next = bus.in_last ? S_OUT : S_ACCUM;
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Beat counter, sticky saturation flag, restart pulse and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      count       <= '0;
      sat_flag_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= accept && (state == S_ACCUM) && bus.in_first;
      if (accept) begin
        if (load)        count <= COUNT_WIDTH'(1);
        else if (!(&count)) count <= count + COUNT_WIDTH'(1);
        sat_flag_r <= load ? 1'b0 : (sat_flag_r | (|lane_sat));
        if (bus.in_last) out_data_r <= cut_bus;
      end
    end
  end

endmodule

// File: tb/tb_element_addition_cut_vec.sv
// Bench: four configurations share one stimulus stream; vectors, hand sequences, random frames.
module tb_element_addition_cut_vec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [31:0] in_data;
  logic        out_ready;

  // dut0 clip CUT=1, dut1 sign tie +1, dut2 sign tie -1, dut3 ACC_WIDTH=8 CUT=100 COUNT_WIDTH=3
  element_addition_cut_vec_if #(.LANES(4), .DATA_WIDTH(8), .COUNT_WIDTH(16)) b0 ();
  element_addition_cut_vec_if #(.LANES(4), .DATA_WIDTH(8), .COUNT_WIDTH(16)) b1 ();
  element_addition_cut_vec_if #(.LANES(4), .DATA_WIDTH(8), .COUNT_WIDTH(16)) b2 ();
  element_addition_cut_vec_if #(.LANES(4), .DATA_WIDTH(8), .COUNT_WIDTH(3))  b3 ();

  assign b0.in_valid = in_valid; assign b0.in_first = in_first; assign b0.in_last = in_last;
  assign b0.in_data  = in_data;  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid; assign b1.in_first = in_first; assign b1.in_last = in_last;
  assign b1.in_data  = in_data;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid; assign b2.in_first = in_first; assign b2.in_last = in_last;
  assign b2.in_data  = in_data;  assign b2.out_ready = out_ready;
  assign b3.in_valid = in_valid; assign b3.in_first = in_first; assign b3.in_last = in_last;
  assign b3.in_data  = in_data;  assign b3.out_ready = out_ready;

  element_addition_cut_vec #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(12), .CUT(1), .MODE(0),
    .TIE_POS(1), .COUNT_WIDTH(16)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  element_addition_cut_vec #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(12), .CUT(1), .MODE(1),
    .TIE_POS(1), .COUNT_WIDTH(16)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  element_addition_cut_vec #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(12), .CUT(1), .MODE(1),
    .TIE_POS(0), .COUNT_WIDTH(16)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  element_addition_cut_vec #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(8), .CUT(100), .MODE(0),
    .TIE_POS(1), .COUNT_WIDTH(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  logic [31:0] od [4];
  logic [15:0] oc [4];
  logic        ov [4];
  logic        sf [4];
  logic        fe [4];
  logic        ir [4];

  assign od[0] = b0.out_data; assign oc[0] = b0.out_count; assign ov[0] = b0.out_valid;
  assign od[1] = b1.out_data; assign oc[1] = b1.out_count; assign ov[1] = b1.out_valid;
  assign od[2] = b2.out_data; assign oc[2] = b2.out_count; assign ov[2] = b2.out_valid;
  assign od[3] = b3.out_data; assign oc[3] = 16'(b3.out_count); assign ov[3] = b3.out_valid;
  assign sf[0] = b0.sat_flag; assign fe[0] = b0.frame_err; assign ir[0] = b0.in_ready;
  assign sf[1] = b1.sat_flag; assign fe[1] = b1.frame_err; assign ir[1] = b1.in_ready;
  assign sf[2] = b2.sat_flag; assign fe[2] = b2.frame_err; assign ir[2] = b2.in_ready;
  assign sf[3] = b3.sat_flag; assign fe[3] = b3.frame_err; assign ir[3] = b3.in_ready;

  // Reference model configuration, one entry per DUT.
  int acc_w [4] = '{12, 12, 12, 8};
  int cut_v [4] = '{1, 1, 1, 100};
  int mode  [4] = '{0, 1, 1, 0};
  int tie   [4] = '{1, 1, 0, 1};
  int cnt_w [4] = '{16, 16, 16, 3};

  int total = 0;
  int bad   = 0;

  bit               open;
  logic [31:0]      beats [$];
  logic [3:0][31:0] eo;
  logic [3:0][15:0] ec;
  logic [3:0]       es;

  typedef struct packed {
    int               n;
    logic [9:0][31:0] data;
    logic [9:0]       first;
    logic [9:0]       last;
    logic [3:0][31:0] exp;
    int               cnt012;
    int               cnt3;
    logic [3:0]       sat;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected results from the beats of the just-closed frame, using plain integer arithmetic.
  task automatic model_frame();
    int acc, hi, lo, r, n, cmax;
    logic signed [7:0] v;
    n = beats.size();
    for (int k = 0; k < 4; k++) begin
      es[k] = 1'b0;
      hi = (1 << (acc_w[k] - 1)) - 1;
      lo = -(1 << (acc_w[k] - 1));
      for (int l = 0; l < 4; l++) begin
        acc = 0;
        for (int j = 0; j < n; j++) begin
          v = beats[j][8*l +: 8];
          if (j == 0) acc = int'(v);
          else begin
            acc = acc + int'(v);
            if (acc > hi) begin acc = hi; es[k] = 1'b1; end
            if (acc < lo) begin acc = lo; es[k] = 1'b1; end
          end
        end
        if (mode[k] == 0) r = (acc > cut_v[k]) ? cut_v[k] : (acc < -cut_v[k]) ? -cut_v[k] : acc;
        else              r = (acc > 0) ? 1 : (acc < 0) ? -1 : (tie[k] != 0 ? 1 : -1);
        eo[k][8*l +: 8] = 8'(r);
      end
      cmax = (1 << cnt_w[k]) - 1;
      ec[k] = 16'((n > cmax) ? cmax : n);
    end
  endtask

  // Present one beat, wait (bounded) for it to be taken, then check against the model.
  task automatic send(input logic f, input logic l, input logic [31:0] d, output int waits);
    bit taken;
    bit exp_fe;
    in_valid = 1'b1; in_first = f; in_last = l; in_data = d;
    taken = 1'b0; waits = 0;
    while (!taken && waits < 40) begin
      @(negedge clk);
      taken = ir[0];
      @(posedge clk); #1;
      if (!taken) waits++;
    end
    if (!taken) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    exp_fe = open && f;
    if (!open || f) beats.delete();
    open = 1'b1;
    beats.push_back(d);
    for (int k = 0; k < 4; k++) check($sformatf("frame_err%0d", k), 64'(fe[k]), 64'(exp_fe));
    if (l) begin
      open = 1'b0;
      model_frame();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid%0d", k), 64'(ov[k]), 64'd1);
        check($sformatf("out_data%0d", k), 64'(od[k]), 64'(eo[k]));
        check($sformatf("out_count%0d", k), 64'(oc[k]), 64'(ec[k]));
        check($sformatf("sat_flag%0d", k), 64'(sf[k]), 64'(es[k]));
        check($sformatf("ready_in_out%0d", k), 64'(ir[k]), 64'd0);
      end
    end
  endtask

  // Hold the result for 'hold' cycles, then take it.
  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(ov[0]), 64'd1);
      check("hold_data", 64'(od[0]), 64'(eo[0]));
      check("hold_count", 64'(oc[0]), 64'(ec[0]));
      check("hold_ready", 64'(ir[0]), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) check($sformatf("drain_valid%0d", k), 64'(ov[k]), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int w;
    for (int j = 0; j < vecs[i].n; j++) send(vecs[i].first[j], vecs[i].last[j], vecs[i].data[j], w);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("vec%0d_data%0d", i, k), 64'(od[k]), 64'(vecs[i].exp[k]));
      check($sformatf("vec%0d_count%0d", i, k), 64'(oc[k]),
            64'((k == 3) ? vecs[i].cnt3 : vecs[i].cnt012));
      check($sformatf("vec%0d_sat%0d", i, k), 64'(sf[k]), 64'(vecs[i].sat[k]));
    end
    drain(1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 64'(ov[k]), 64'd0);
      check($sformatf("%s_data%0d", tag, k), 64'(od[k]), 64'd0);
      check($sformatf("%s_count%0d", tag, k), 64'(oc[k]), 64'd0);
      check($sformatf("%s_sat%0d", tag, k), 64'(sf[k]), 64'd0);
      check($sformatf("%s_ferr%0d", tag, k), 64'(fe[k]), 64'd0);
      check($sformatf("%s_ready%0d", tag, k), 64'(ir[k]), 64'd0);
    end
  endtask

  initial begin
    int w, n, gap;
    bit wide;
    logic f;
    logic [31:0] d;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // basic clip, back-to-back
    vecs[0].n = 3; vecs[0].first = 10'b1; vecs[0].last = 10'b100;
    vecs[0].data[0] = pack4(1, -1, 1, 1); vecs[0].data[1] = pack4(1, 1, -1, 1);
    vecs[0].data[2] = pack4(1, -1, -1, -1);
    vecs[0].exp[0] = pack4(1, -1, -1, 1); vecs[0].exp[1] = pack4(1, -1, -1, 1);
    vecs[0].exp[2] = pack4(1, -1, -1, 1); vecs[0].exp[3] = pack4(3, -1, -1, 1);
    vecs[0].cnt012 = 3; vecs[0].cnt3 = 3;
    // sign tie, frame opened without in_first
    vecs[1].n = 2; vecs[1].first = 10'b0; vecs[1].last = 10'b10;
    vecs[1].data[0] = pack4(1, -1, 2, 0); vecs[1].data[1] = pack4(-1, 1, -3, 0);
    vecs[1].exp[0] = pack4(0, 0, -1, 0); vecs[1].exp[1] = pack4(1, 1, -1, 1);
    vecs[1].exp[2] = pack4(-1, -1, -1, -1); vecs[1].exp[3] = pack4(0, 0, -1, 0);
    vecs[1].cnt012 = 2; vecs[1].cnt3 = 2;
    // positive saturation
    vecs[2].n = 5; vecs[2].first = 10'b1; vecs[2].last = 10'b10000;
    for (int j = 0; j < 5; j++) vecs[2].data[j] = pack4(127, 127, 127, 127);
    for (int k = 0; k < 3; k++) vecs[2].exp[k] = pack4(1, 1, 1, 1);
    vecs[2].exp[3] = pack4(100, 100, 100, 100);
    vecs[2].cnt012 = 5; vecs[2].cnt3 = 5; vecs[2].sat = 4'b1000;
    // restart with in_first inside an open frame
    vecs[3].n = 4; vecs[3].first = 10'b101; vecs[3].last = 10'b1000;
    vecs[3].data[0] = pack4(5, 5, 5, 5); vecs[3].data[1] = pack4(5, 5, 5, 5);
    vecs[3].data[2] = pack4(1, 1, 1, 1); vecs[3].data[3] = pack4(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) vecs[3].exp[k] = pack4(1, 1, 1, 1);
    vecs[3].exp[3] = pack4(2, 2, 2, 2);
    vecs[3].cnt012 = 2; vecs[3].cnt3 = 2;
    // one-beat frame after reset
    vecs[4].n = 1; vecs[4].first = 10'b1; vecs[4].last = 10'b1;
    vecs[4].data[0] = pack4(-3, 0, 3, 1);
    vecs[4].exp[0] = pack4(-1, 0, 1, 1); vecs[4].exp[1] = pack4(-1, 1, 1, 1);
    vecs[4].exp[2] = pack4(-1, -1, 1, 1); vecs[4].exp[3] = pack4(-3, 0, 3, 1);
    vecs[4].cnt012 = 1; vecs[4].cnt3 = 1;
    // negative saturation and count saturation on the 3-bit counter
    vecs[5].n = 9; vecs[5].first = 10'b1; vecs[5].last = 10'b100000000;
    for (int j = 0; j < 9; j++) vecs[5].data[j] = pack4(-128, -128, -128, -128);
    for (int k = 0; k < 3; k++) vecs[5].exp[k] = pack4(-1, -1, -1, -1);
    vecs[5].exp[3] = pack4(-100, -100, -100, -100);
    vecs[5].cnt012 = 9; vecs[5].cnt3 = 7; vecs[5].sat = 4'b1000;

    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; open = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(ir[0]), 64'd1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Reset mid-frame: partial frame is discarded.
    send(1'b1, 1'b0, pack4(5, 5, 5, 5), w);
    send(1'b0, 1'b0, pack4(5, 5, 5, 5), w);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("ready_in_reset", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    check_reset_state("midrst");
    reset = 1'b0;
    open = 1'b0;
    beats.delete();
    #1;
    check("ready_after_midrst", 64'(ir[0]), 64'd1);

    for (int i = 4; i < 6; i++) run_vec(i);

    // Backpressure with a beat held on the input during S_OUT.
    send(1'b1, 1'b1, pack4(7, -7, 0, 2), w);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = pack4(2, 2, -2, 0);
    drain(5);
    send(1'b1, 1'b1, pack4(2, 2, -2, 0), w);
    check("accept_after_drain_wait", 64'(w), 64'd0);
    check("bp_next_data", 64'(od[0]), 64'(pack4(1, 1, -1, 0)));
    in_valid = 1'b0;
    drain(0);

    // Random frames against the model.
    for (int fr = 0; fr < 40; fr++) begin
      n = $urandom_range(1, 10);
      wide = 1'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) begin
        for (int l = 0; l < 4; l++)
          d[8*l +: 8] = wide ? 8'($urandom) : 8'(int'($urandom_range(0, 8)) - 4);
        f = (j == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
        send(f, (j == n - 1), d, w);
        if (j < n - 1 && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          gap = $urandom_range(1, 2);
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b0;
      drain($urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/element_addition_cut_vec.md
# element_addition_cut_vec

Multi-lane, parametrised successor to the single-lane floating-point add-and-cut bundler. It accumulates a framed stream of bipolar hypervector chunks element-wise in saturating fixed-point, accepting one beat per cycle with no adder stall. At end of frame it emits a cut (clipped) or sign-thresholded chunk through a valid/ready output. It sits in the bundling stage between the HV memory address sequencer and the downstream HV store.

## Interface
- LANES, 8: elements per beat.
- DATA_WIDTH, 8: signed width of each input and output element.
- ACC_WIDTH, 16: signed accumulator width per lane; must be ≥ DATA_WIDTH.
- CUT, 1: positive clip magnitude; must be ≤ 2^(DATA_WIDTH-1)-1.
- MODE, 0: 0 = clip to ±CUT; 1 = sign to ±1.
- TIE_POS, 1: MODE 1 only; result for an accumulator of 0 (1 → +1, 0 → −1).
- COUNT_WIDTH, 16: width of the beat counter.
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_first  in  1  first beat of frame.
- in_last  in  1  last beat of frame.
- in_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- in_ready  out  1  block can accept a beat.
- out_valid  out  1  result held on out_data/out_count.
- out_ready  in  1  downstream accepts result.
- out_data  out  LANES*DATA_WIDTH  cut or signed result, same lane packing.
- out_count  out  COUNT_WIDTH  beats bundled in frame; saturates at all-ones.
- sat_flag  out  1  sticky per frame: any lane saturated during the frame.
- frame_err  out  1  one-cycle pulse: in_first seen while a frame was open.

## Operation
- Beat accepted when in_valid && in_ready.
- States:
  - S_IDLE: in_ready=1. On accept, acc[i] ← sext(lane i) and count ← 1. If in_last, go to S_OUT; else go to S_ACCUM. in_first is not required in S_IDLE.
  - S_ACCUM: in_ready=1.
    - Accept with in_first: acc reload as in S_IDLE, count ← 1, sat_flag cleared, frame_err pulses.
    - Otherwise: acc[i] ← sat(acc[i] + sext(lane i)), clamped to [−2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)−1]; any clamp sets sat_flag; count ← count+1, saturating.
    - Accept with in_last: go to S_OUT.
  - S_OUT: in_ready=0, out_valid=1, outputs frozen. When out_ready, go to S_IDLE.
- Final beat: the accumulation including the final beat is computed, then cut into the out_data register in the same edge.
- Cut rule:
  - MODE 0: out = acc > CUT ? CUT : acc < −CUT ? −CUT : acc[DATA_WIDTH-1:0].
  - MODE 1: out = acc > 0 ? +1 : acc < 0 ? −1 : (TIE_POS ? +1 : −1).
- A beat carrying both in_first and in_last is a complete one-beat frame.
- sat_flag: cleared on each frame start; held through S_OUT.
- Reset takes priority over every event. Reset mid-frame discards the frame; no partial output is produced.

## Timing
- Reset values: out_valid 0, out_data 0, out_count 0, sat_flag 0, frame_err 0, acc 0, state S_IDLE.
- in_ready is 0 during the reset cycle and 1 the first cycle after reset deasserts.
- Throughput: 1 beat/cycle inside a frame.
- Latency: last beat accepted at edge t → out_valid=1 from t (visible the cycle after the accept).
- in_ready is a registered-state decode (state==S_IDLE||S_ACCUM) gated by reset; it does not depend on out_ready.
- Output drain:
  - Handshake at edge t → out_valid=0 after t; the next beat is accepted no earlier than edge t+1.
  - Minimum gap between frames: 1 cycle.
- Beats presented during S_OUT are not accepted; the source must hold them.
- frame_err is high for exactly the cycle following the offending accept.

## Structure
- Package element_addition_cut_pkg holds:
  - the state enum (S_IDLE, S_ACCUM, S_OUT);
  - the mode constants CUT_MODE_CLIP=0 and CUT_MODE_SIGN=1;
  - the function for the saturating add.
- Sub-module bipolar_sat_accum_lane, instanced LANES times, holds:
  - one lane's accumulator, the saturating add and the cut logic;
  - a sat output that the top ORs across lanes.
- The top holds the FSM, beat counter, flags and output register control.

## Test plan
All scenarios use LANES=4, DATA_WIDTH=8, ACC_WIDTH=12, CUT=1 unless noted.
- Basic clip: beats {1,-1,1,1},{1,1,-1,1},{1,-1,-1,-1}, back-to-back, last on beat 3 → sums {3,-1,-1,1}; out_data {1,-1,-1,1}, out_count 3, out_valid the cycle after the 3rd accept, sat_flag 0.
- Sign mode tie: MODE=1, TIE_POS=1; beats {1,-1,2,0},{-1,1,-3,0} → out_data {1,1,-1,1}. With TIE_POS=0 → {-1,-1,-1,-1}.
- Saturation: ACC_WIDTH=8, CUT=100; five beats of 127 on all lanes → acc 127 on every lane, sat_flag 1, out_data 100 on every lane, out_count 5.
- Backpressure: out_ready low for 5 cycles with in_valid high → out_valid, out_data and out_count stable; in_ready 0; no beat consumed. out_ready high → next beat accepted one cycle later.
- Restart: beats {5,5,5,5},{5,...}, then a beat {1,1,1,1} with in_first, then last {1,1,1,1} → frame_err one-cycle pulse, out_data {1,1,1,1} (sum 2 clipped), out_count 2.
- Reset mid-frame: reset asserted after 2 beats → all outputs 0 and in_ready 0 in the reset cycle. Next single-beat frame {-3,0,3,1} → out_data {-1,0,1,1}, out_count 1.
